memory_responder: RTL and testbench

MEMORY_RESPONDER -- requirements
Module: memory_responder

---
 rtl/mpt_pkg.sv | 18 +
 rtl/mem_resp_delay_line.sv | 38 +++
 rtl/memory_responder.sv | 138 +++++++++++++
 tb/tb_memory_responder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpt_pkg.sv
// Shared constants for memory_responder: stall-LFSR seed and step function,
// plus the legal ranges of the latency and outstanding-request parameters.
package mpt_pkg;

    localparam logic [15:0] LFSR_SEED           = 16'hACE1;
    localparam int          READ_LATENCY_MIN    = 1;
    localparam int          READ_LATENCY_MAX    = 8;
    localparam int          MAX_OUTSTANDING_MIN = 1;
    localparam int          MAX_OUTSTANDING_MAX = 8;
    // Wide enough to hold MAX_OUTSTANDING_MAX itself
    localparam int          OUTSTANDING_W       = $clog2(MAX_OUTSTANDING_MAX + 1);

    // Fibonacci LFSR step, taps 16,14,13,11
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], cur[15] ^ cur[13] ^ cur[12] ^ cur[10]};
    endfunction

endpackage

// File: rtl/mem_resp_delay_line.sv
// Fixed-depth {valid, data} shift register carrying responses from accept to
// the response port; synchronous active-high reset empties every stage.
module mem_resp_delay_line #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_valid,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_data
);

    logic [DEPTH-1:0]      valid_r;
    logic [DATA_WIDTH-1:0] data_r [DEPTH];

    // Advance every token one stage per cycle; data is zeroed for empty slots
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_r[i] <= '0;
            end
        end else begin
            valid_r[0] <= push_valid;
            data_r[0]  <= push_valid ? push_data : '0;
            for (int i = 1; i < DEPTH; i++) begin
                valid_r[i] <= valid_r[i-1];
                data_r[i]  <= data_r[i-1];
            end
        end
    end

    assign resp_valid = valid_r[DEPTH-1];
    assign resp_data  = data_r[DEPTH-1];

endmodule

// File: rtl/memory_responder.sv
// memory_responder: word-organised memory with fixed-latency, in-order responses.
// Define MEMORY_RESPONDER_STALL_EN to inject pseudo-random grant stalls.
module memory_responder
    import mpt_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int NUM_WORDS       = 1024,
    parameter int READ_LATENCY    = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    memory_slave_mem_req,
    output logic                    memory_slave_mem_gnt,
    input  logic [ADDR_WIDTH-1:0]   memory_slave_mem_addr,
    input  logic                    memory_slave_mem_we,
    input  logic [DATA_WIDTH/8-1:0] memory_slave_mem_be,
    input  logic [DATA_WIDTH-1:0]   memory_slave_mem_wdata,
    output logic                    memory_slave_mem_valid,
    output logic [DATA_WIDTH-1:0]   memory_slave_mem_rdata
);

    localparam int BYTES      = DATA_WIDTH / 8;
    localparam int BYTE_SHIFT = $clog2(BYTES);
    localparam int IDX_W      = $clog2(NUM_WORDS);

    if (READ_LATENCY < READ_LATENCY_MIN || READ_LATENCY > READ_LATENCY_MAX ||
        MAX_OUTSTANDING < MAX_OUTSTANDING_MIN || MAX_OUTSTANDING > MAX_OUTSTANDING_MAX)
    begin : g_param_range_error
        $error("memory_responder: READ_LATENCY or MAX_OUTSTANDING out of range");
    end

    logic [DATA_WIDTH-1:0]    mem_r [NUM_WORDS];
    logic [ADDR_WIDTH-1:0]    word_addr_s;
    logic [IDX_W-1:0]         word_idx_s;
    logic                     unused_addr_s;
    logic [OUTSTANDING_W-1:0] outstanding_r;
    logic                     slot_free_s;
    logic                     stall_s;
    logic                     gnt_s;
    logic                     accept_s;
    logic [DATA_WIDTH-1:0]    push_data_s;
    logic                     dl_valid_s;
    logic [DATA_WIDTH-1:0]    dl_data_s;

    // Word index wraps modulo NUM_WORDS; upper address bits are ignored
    assign word_addr_s   = memory_slave_mem_addr >> BYTE_SHIFT;
    assign word_idx_s    = word_addr_s[IDX_W-1:0];
    assign unused_addr_s = ^word_addr_s;

`ifdef MEMORY_RESPONDER_STALL_EN
    logic [15:0] lfsr_r;

    // Free-running stall generator
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_r <= LFSR_SEED;
        end else begin
            lfsr_r <= lfsr_next(lfsr_r);
        end
    end

    assign stall_s = (lfsr_r[1:0] == 2'b11);
`else
    assign stall_s = 1'b0;
`endif

    // Grant: a response leaving this cycle frees its slot for a new accept
    always_comb begin
        slot_free_s = 1'b0;
        gnt_s       = 1'b0;
        if (outstanding_r < OUTSTANDING_W'(MAX_OUTSTANDING)) begin
            slot_free_s = 1'b1;
        end else begin
            slot_free_s = memory_slave_mem_valid;
        end
        if (rst_i) begin
            gnt_s = 1'b0;
        end else begin
            gnt_s = memory_slave_mem_req && slot_free_s && !stall_s;
        end
    end

    assign memory_slave_mem_gnt = gnt_s;
    assign accept_s             = gnt_s;

    // Track accepted-but-unanswered requests
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            outstanding_r <= '0;
        end else begin
            case ({accept_s, memory_slave_mem_valid})
                2'b10:   outstanding_r <= outstanding_r + OUTSTANDING_W'(1);
                2'b01:   outstanding_r <= outstanding_r - OUTSTANDING_W'(1);
                default: outstanding_r <= outstanding_r;
            endcase
        end
    end

    // Byte-masked write at the accept edge; storage keeps its contents across reset
    always_ff @(posedge clk_i) begin
        if (accept_s && memory_slave_mem_we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (memory_slave_mem_be[b]) begin
                    mem_r[word_idx_s][b*8 +: 8] <= memory_slave_mem_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Reads sample the array in the accept cycle; write responses carry zero
    always_comb begin
        push_data_s = '0;
        if (accept_s && !memory_slave_mem_we) begin
            push_data_s = mem_r[word_idx_s];
        end else begin
            push_data_s = '0;
        end
    end

    mem_resp_delay_line #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (READ_LATENCY)
    ) u_delay_line (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_valid (accept_s),
        .push_data  (push_data_s),
        .resp_valid (dl_valid_s),
        .resp_data  (dl_data_s)
    );

    // Response port reads as idle for the whole time reset is held
    assign memory_slave_mem_valid = dl_valid_s & ~rst_i;
    assign memory_slave_mem_rdata = rst_i ? '0 : dl_data_s;

endmodule

// File: tb/tb_memory_responder.sv
// Directed self-checking bench for memory_responder (default configuration plus
// a MAX_OUTSTANDING=1 / READ_LATENCY=3 instance), with a scoreboarded random run.
module tb_memory_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, we;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic        gnt, valid;
    logic [31:0] rdata;
    logic        req2, gnt2, valid2;
    logic [31:0] rdata2;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [31:0] model_mem [16];

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    always #5 clk = ~clk;

`ifdef MEMORY_RESPONDER_STALL_EN
    logic [15:0] lfsr_m;
    always @(posedge clk) begin
        if (rst) lfsr_m <= 16'hACE1;
        else     lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    end
`endif

    memory_responder dut (
        .clk_i                  (clk),
        .rst_i                  (rst),
        .memory_slave_mem_req   (req),
        .memory_slave_mem_gnt   (gnt),
        .memory_slave_mem_addr  (addr),
        .memory_slave_mem_we    (we),
        .memory_slave_mem_be    (be),
        .memory_slave_mem_wdata (wdata),
        .memory_slave_mem_valid (valid),
        .memory_slave_mem_rdata (rdata)
    );

    memory_responder #(.READ_LATENCY(3), .MAX_OUTSTANDING(1)) dut2 (
        .clk_i                  (clk),
        .rst_i                  (rst),
        .memory_slave_mem_req   (req2),
        .memory_slave_mem_gnt   (gnt2),
        .memory_slave_mem_addr  (32'h0000_0000),
        .memory_slave_mem_we    (1'b0),
        .memory_slave_mem_be    (4'h0),
        .memory_slave_mem_wdata (32'h0000_0000),
        .memory_slave_mem_valid (valid2),
        .memory_slave_mem_rdata (rdata2)
    );

    task automatic set_req(input logic r, input logic w, input logic [31:0] a,
                           input logic [3:0] b, input logic [31:0] d);
        req = r; we = w; addr = a; be = b; wdata = d;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req2 = 1'b1;
        set_req(1'b1, 1'b0, 32'd20, 4'hF, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            total_cnt++; if (gnt !== 1'b0)     $display("FAIL rst_gnt: got %b want 0", gnt); else pass_cnt++;
            total_cnt++; if (valid !== 1'b0)   $display("FAIL rst_valid: got %b want 0", valid); else pass_cnt++;
            total_cnt++; if (rdata !== 32'h0)  $display("FAIL rst_rdata: got %h want 0", rdata); else pass_cnt++;
            total_cnt++; if (gnt2 !== 1'b0)    $display("FAIL rst_gnt2: got %b want 0", gnt2); else pass_cnt++;
        end
        total_cnt++; if (dut.outstanding_r !== 4'd0) $display("FAIL rst_count: got %0d want 0", dut.outstanding_r); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        req2 = 1'b0;
        set_req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic test_read_latency;
        // preload word 5, then read it back with latency 2
        @(negedge clk); set_req(1'b1, 1'b1, 32'd20, 4'hF, 32'hDEADBEEF); #1;
        total_cnt++; if (gnt !== 1'b1) $display("FAIL wr5_gnt: got %b want 1", gnt); else pass_cnt++;
        @(negedge clk); set_req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0); #1;
        total_cnt++; if (valid !== 1'b0) $display("FAIL wr5_early: got valid %b want 0", valid); else pass_cnt++;
        @(negedge clk); #1;
        total_cnt++; if (valid !== 1'b1)  $display("FAIL wr5_valid: got %b want 1", valid); else pass_cnt++;
        total_cnt++; if (rdata !== 32'h0) $display("FAIL wr5_rdata: got %h want 0", rdata); else pass_cnt++;
        @(negedge clk); set_req(1'b1, 1'b0, 32'd20, 4'h0, 32'h0); #1;
        total_cnt++; if (gnt !== 1'b1) $display("FAIL rd5_gnt: got %b want 1", gnt); else pass_cnt++;
        @(negedge clk); set_req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0); #1;
        total_cnt++; if (valid !== 1'b0) $display("FAIL rd5_early: got valid %b want 0", valid); else pass_cnt++;
        @(negedge clk); #1;
        total_cnt++; if (valid !== 1'b1)         $display("FAIL rd5_valid: got %b want 1", valid); else pass_cnt++;
        total_cnt++; if (rdata !== 32'hDEADBEEF) $display("FAIL rd5_rdata: got %h want deadbeef", rdata); else pass_cnt++;
        @(negedge clk); #1;
        total_cnt++; if (valid !== 1'b0)  $display("FAIL rd5_pulse: got valid %b want 0", valid); else pass_cnt++;
        total_cnt++; if (rdata !== 32'h0) $display("FAIL rd5_idle_rdata: got %h want 0", rdata); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        // clear 0x10, partial write, then read in the very next cycle
        @(negedge clk); set_req(1'b1, 1'b1, 32'h10, 4'hF, 32'h0); #1;
        total_cnt++; if (gnt !== 1'b1) $display("FAIL b2b_gnt0: got %b want 1", gnt); else pass_cnt++;
        @(negedge clk); set_req(1'b1, 1'b1, 32'h10, 4'b0101, 32'h11223344); #1;
        total_cnt++; if (gnt !== 1'b1) $display("FAIL b2b_gnt1: got %b want 1", gnt); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (valid !== 1'b1 || rdata !== 32'h0) $display("FAIL b2b_resp0: got %b/%h want 1/0", valid, rdata); else pass_cnt++;
        set_req(1'b1, 1'b0, 32'h10, 4'h0, 32'h0); #1;
        total_cnt++; if (gnt !== 1'b1) $display("FAIL b2b_gnt2: got %b want 1", gnt); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (valid !== 1'b1 || rdata !== 32'h0) $display("FAIL b2b_resp1: got %b/%h want 1/0", valid, rdata); else pass_cnt++;
        set_req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk); #1;
        total_cnt++; if (valid !== 1'b1 || rdata !== 32'h00220044) $display("FAIL b2b_resp2: got %b/%h want 1/00220044", valid, rdata); else pass_cnt++;
        @(negedge clk); #1;
        total_cnt++; if (valid !== 1'b0) $display("FAIL b2b_end: got valid %b want 0", valid); else pass_cnt++;
    endtask

    task automatic test_wrap;
        // 0x1008 and 0x100C alias words 2 and 3 of a 1024-word array
        @(negedge clk); set_req(1'b1, 1'b1, 32'h8, 4'hF, 32'hCAFEF00D); #1;
        total_cnt++; if (gnt !== 1'b1) $display("FAIL wrap_gnt0: got %b want 1", gnt); else pass_cnt++;
        @(negedge clk); set_req(1'b1, 1'b1, 32'h100C, 4'hF, 32'h0BADC0DE); #1;
        @(negedge clk); set_req(1'b1, 1'b0, 32'h1008, 4'h0, 32'h0); #1;
        @(negedge clk); set_req(1'b1, 1'b0, 32'hC, 4'h0, 32'h0); #1;
        @(negedge clk); set_req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0); #1;
        total_cnt++; if (valid !== 1'b1 || rdata !== 32'hCAFEF00D) $display("FAIL wrap_hi: got %b/%h want 1/cafef00d", valid, rdata); else pass_cnt++;
        @(negedge clk); #1;
        total_cnt++; if (valid !== 1'b1 || rdata !== 32'h0BADC0DE) $display("FAIL wrap_lo: got %b/%h want 1/0badc0de", valid, rdata); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_max_outstanding;
        logic exp_g, exp_v;
        @(negedge clk); req2 = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            exp_g = (c % 3 == 0);
            exp_v = (c % 3 == 0) && (c > 0);
            total_cnt++; if (gnt2 !== exp_g)   $display("FAIL mo_gnt c%0d: got %b want %b", c, gnt2, exp_g); else pass_cnt++;
            total_cnt++; if (valid2 !== exp_v) $display("FAIL mo_valid c%0d: got %b want %b", c, valid2, exp_v); else pass_cnt++;
            if (!exp_v) begin
                total_cnt++; if (rdata2 !== 32'h0) $display("FAIL mo_rdata c%0d: got %h want 0", c, rdata2); else pass_cnt++;
            end
        end
        @(negedge clk); req2 = 1'b0;
    endtask

    task automatic test_reset_inflight;
        @(negedge clk); set_req(1'b1, 1'b0, 32'd20, 4'h0, 32'h0); #1;
        total_cnt++; if (gnt !== 1'b1) $display("FAIL rif_gnt0: got %b want 1", gnt); else pass_cnt++;
        @(negedge clk); set_req(1'b1, 1'b0, 32'd8, 4'h0, 32'h0); #1;
        total_cnt++; if (gnt !== 1'b1) $display("FAIL rif_gnt1: got %b want 1", gnt); else pass_cnt++;
        @(negedge clk); rst = 1'b1; set_req(1'b1, 1'b0, 32'd20, 4'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            total_cnt++; if (valid !== 1'b0) $display("FAIL rif_valid_in_rst %0d: got %b want 0", i, valid); else pass_cnt++;
            total_cnt++; if (gnt !== 1'b0)   $display("FAIL rif_gnt_in_rst %0d: got %b want 0", i, gnt); else pass_cnt++;
        end
        @(negedge clk); rst = 1'b0; set_req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0); #1;
        total_cnt++; if (dut.outstanding_r !== 4'd0) $display("FAIL rif_count: got %0d want 0", dut.outstanding_r); else pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            total_cnt++; if (valid !== 1'b0) $display("FAIL rif_stale %0d: got valid %b want 0", i, valid); else pass_cnt++;
        end
        // grant resumes and storage survived reset
        @(negedge clk); set_req(1'b1, 1'b0, 32'd20, 4'h0, 32'h0); #1;
        total_cnt++; if (gnt !== 1'b1) $display("FAIL rif_resume: got %b want 1", gnt); else pass_cnt++;
        @(negedge clk); set_req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk); #1;
        total_cnt++; if (valid !== 1'b1 || rdata !== 32'hDEADBEEF) $display("FAIL rif_keep: got %b/%h want 1/deadbeef", valid, rdata); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_random;
        exp_t        expq[$];
        exp_t        e;
        int          issued, cyc, w;
        bit          need_new;
        logic        r_we;
        logic [31:0] r_addr, r_wdata;
        logic [3:0]  r_be;
        issued = 0; cyc = 0; need_new = 1'b1;
        r_we = 1'b0; r_addr = 32'h0; r_wdata = 32'h0; r_be = 4'h0;
        while ((issued < 216 || expq.size() != 0) && cyc < 5000) begin
            @(negedge clk); cyc++;
            if (valid) begin
                total_cnt++;
                if (expq.size() == 0) begin
                    $display("FAIL rnd_extra: got unexpected valid rdata %h at cycle %0d", rdata, cyc);
                end else begin
                    e = expq.pop_front();
                    if (rdata !== e.data || cyc - e.cyc != 2)
                        $display("FAIL rnd_resp: got %h after %0d cycles want %h after 2", rdata, cyc - e.cyc, e.data);
                    else pass_cnt++;
                end
            end
            if (issued < 216) begin
                if (need_new) begin
                    if (issued < 16) begin
                        r_we = 1'b1; r_be = 4'hF;
                        r_addr = issued * 4; r_wdata = 32'h5A00_0000 + issued;
                    end else begin
                        r_we = 1'($urandom_range(0, 1)); r_be = 4'($urandom_range(0, 15));
                        r_wdata = $urandom;
                        r_addr = $urandom_range(0, 3) * 4096 + $urandom_range(0, 15) * 4 + $urandom_range(0, 3);
                    end
                    need_new = 1'b0;
                end
                set_req(1'b1, r_we, r_addr, r_be, r_wdata);
            end else begin
                set_req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
            end
            #1;
`ifdef MEMORY_RESPONDER_STALL_EN
            if (lfsr_m[1:0] == 2'b11) begin
                total_cnt++; if (gnt !== 1'b0) $display("FAIL rnd_stall: got gnt %b want 0", gnt); else pass_cnt++;
            end
`endif
            if (req && gnt) begin
                w = (r_addr >> 2) % 16;
                e.cyc = cyc;
                e.data = r_we ? 32'h0 : model_mem[w];
                expq.push_back(e);
                if (r_we) begin
                    for (int b = 0; b < 4; b++) begin
                        if (r_be[b]) model_mem[w][b*8 +: 8] = r_wdata[b*8 +: 8];
                    end
                end
                issued++;
                need_new = 1'b1;
            end
        end
        set_req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        total_cnt++;
        if (issued != 216 || expq.size() != 0)
            $display("FAIL rnd_drain: got %0d issued %0d pending want 216 issued 0 pending", issued, expq.size());
        else pass_cnt++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want $finish");
        $fatal(1);
    end

    initial begin
        req2 = 1'b0;
        set_req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        test_reset();
        test_read_latency();
        test_back_to_back();
        test_wrap();
        test_max_outstanding();
        test_reset_inflight();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
